bsn_block_assembler: RTL and testbench

- Downstream consumer of the timeslot selection table, on the business (bsn) path.
- For one timeslot, walks LDPC blocks 0..N-1. Per block it issues a table read, then streams exactly BLOCK_BYTES bytes to the LDPC encoder.
- Each byte is taken from the business FIFO where the table's per-byte flag is set. Everywhere else, and on FIFO underflow, FILL_BYTE is inserted.

---
 rtl/bsn_pkg.sv | 18 +
 rtl/sat_cnt16.sv | 16 +
 rtl/bsn_block_assembler.sv | 107 ++++++++++
 tb/tb_bsn_block_assembler.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsn_pkg.sv
// Shared constants, FSM encoding and table-index helper for the bsn block assemblers.
package bsn_pkg;

    localparam int         BLOCK_BYTES = 480;
    localparam int         LDPC_MAX    = 32;
    localparam logic [7:0] FILL_BYTE   = 8'h00;
    localparam int         TS_IDX_W    = 10;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    function automatic logic [TS_IDX_W-1:0] ts_index(input logic [4:0] ts, input logic [4:0] idx);
        return {ts, idx};
    endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 16'd0;
        else if (inc && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/bsn_block_assembler.sv
// Walks the LDPC blocks of one timeslot, reading the selection table per block and
// streaming BLOCK_BYTES bytes from the business FIFO or FILL_BYTE to the encoder.
module bsn_block_assembler
    import bsn_pkg::*;
(
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [4:0]  frame_timeslot,
    input  logic [5:0]  frame_ldpc_num,
    output logic        busy,
    output logic        bsn_byte_rd,
    output logic [9:0]  bsn_timeslot,
    input  logic        bsn_ts_vld,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd_en,
    output logic        blk_vld,
    output logic [7:0]  blk_data,
    output logic        blk_sop,
    output logic        blk_eop,
    output logic [4:0]  blk_ldpc_idx,
    output logic        frame_done,
    output logic [15:0] underflow_cnt
);

    logic [1:0] state, state_nx;
    logic [4:0] ts_q;
    logic [5:0] num_q;
    logic [4:0] ldpc_idx;
    logic [8:0] byte_cnt;
    logic [5:0] num_in;
    logic       in_stream, take, unf, last_byte, last_blk;

    assign num_in    = (frame_ldpc_num > 6'(LDPC_MAX)) ? 6'(LDPC_MAX) : frame_ldpc_num;
    assign in_stream = (state == S_STREAM);
    assign take      = in_stream && bsn_ts_vld && !fifo_empty;
    assign unf       = in_stream && bsn_ts_vld && fifo_empty;
    assign last_byte = (byte_cnt == 9'(BLOCK_BYTES - 1));
    assign last_blk  = ({1'b0, ldpc_idx} == num_q - 6'd1);

    // FIFO is first-word-fall-through, so the pop goes out in the same cycle the byte is used.
    assign fifo_rd_en = take;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (frame_start) state_nx = (num_in == 6'd0) ? S_DONE : S_REQ;
            S_REQ:    state_nx = S_STREAM;
            S_STREAM: if (last_byte) state_nx = last_blk ? S_DONE : S_REQ;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ts_q         <= 5'd0;
            num_q        <= 6'd0;
            ldpc_idx     <= 5'd0;
            byte_cnt     <= 9'd0;
            busy         <= 1'b0;
            bsn_byte_rd  <= 1'b0;
            bsn_timeslot <= 10'd0;
            blk_vld      <= 1'b0;
            blk_data     <= 8'd0;
            blk_sop      <= 1'b0;
            blk_eop      <= 1'b0;
            blk_ldpc_idx <= 5'd0;
            frame_done   <= 1'b0;
        end else begin
            state    <= state_nx;
            byte_cnt <= (in_stream && !last_byte) ? byte_cnt + 9'd1 : 9'd0;
            if (state == S_IDLE && frame_start) begin
                ts_q     <= frame_timeslot;
                num_q    <= num_in;
                ldpc_idx <= 5'd0;
            end else if (in_stream && last_byte && !last_blk) begin
                ldpc_idx <= ldpc_idx + 5'd1;
            end

            // Table request is registered so it is valid throughout the REQ cycle.
            bsn_byte_rd <= (state_nx == S_REQ);
            if (state_nx == S_REQ)
                bsn_timeslot <= (state == S_IDLE) ? ts_index(frame_timeslot, 5'd0)
                                                  : ts_index(ts_q, ldpc_idx + 5'd1);

            blk_vld  <= in_stream;
            blk_sop  <= in_stream && (byte_cnt == 9'd0);
            blk_eop  <= in_stream && last_byte;
            blk_data <= take ? fifo_dout : FILL_BYTE;
            if (in_stream)
                blk_ldpc_idx <= ldpc_idx;

            frame_done <= (state == S_DONE);
            busy       <= (state == S_IDLE) ? frame_start : (state != S_DONE);
        end
    end

    sat_cnt16 u_unf_cnt (
        .clk (sys_clk),
        .rst (rst),
        .inc (unf),
        .cnt (underflow_cnt)
    );

endmodule

// File: tb/tb_bsn_block_assembler.sv
// Directed bench: table-flag and FIFO models drive the assembler, a negedge monitor records activity.
module tb_bsn_block_assembler;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [4:0]  frame_timeslot = 5'd0;
    logic [5:0]  frame_ldpc_num = 6'd0;
    logic        busy, bsn_byte_rd, bsn_ts_vld, fifo_empty, fifo_rd_en;
    logic [9:0]  bsn_timeslot;
    logic [7:0]  fifo_dout, blk_data;
    logic        blk_vld, blk_sop, blk_eop, frame_done;
    logic [4:0]  blk_ldpc_idx;
    logic [15:0] underflow_cnt;

    int tests = 0;
    int fails = 0;

    always #5 sys_clk = ~sys_clk;

    bsn_block_assembler dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .frame_timeslot (frame_timeslot),
        .frame_ldpc_num (frame_ldpc_num),
        .busy           (busy),
        .bsn_byte_rd    (bsn_byte_rd),
        .bsn_timeslot   (bsn_timeslot),
        .bsn_ts_vld     (bsn_ts_vld),
        .fifo_empty     (fifo_empty),
        .fifo_dout      (fifo_dout),
        .fifo_rd_en     (fifo_rd_en),
        .blk_vld        (blk_vld),
        .blk_data       (blk_data),
        .blk_sop        (blk_sop),
        .blk_eop        (blk_eop),
        .blk_ldpc_idx   (blk_ldpc_idx),
        .frame_done     (frame_done),
        .underflow_cnt  (underflow_cnt)
    );

    // Table model: flags set for the first flag_lim bytes after each read. FIFO model holds
    // fifo_cnt bytes valued 1,2,3,... counted from pop_base.
    int tcnt = 100000;
    int flag_lim = 0;
    int pop_total = 0;
    int pop_base = 0;
    int fifo_cnt = 0;

    assign bsn_ts_vld = (tcnt < flag_lim);
    assign fifo_empty = ((pop_total - pop_base) >= fifo_cnt);
    assign fifo_dout  = 8'(pop_total - pop_base + 1);

    always @(posedge sys_clk) begin
        if (fifo_rd_en) pop_total <= pop_total + 1;
        tcnt <= bsn_byte_rd ? 0 : ((tcnt < 100000) ? tcnt + 1 : tcnt);
    end

    // Monitor, cleared whenever gen changes.
    int gen = 0, gen_seen = 0, cyc = 0;
    int start_cyc, first_vld, done_cyc, done_cnt, rd_cnt, vld_cnt, sop_cnt, eop_cnt, pos;
    int rd_ts[0:63];
    int sop_cyc[0:63];
    int sop_idx[0:63];
    int eop_cyc[0:63];
    int eop_pos[0:63];
    logic [7:0] bdat[0:479];

    always @(negedge sys_clk) begin
        cyc <= cyc + 1;
        if (gen != gen_seen) begin
            gen_seen  <= gen;
            start_cyc <= -1;
            first_vld <= -1;
            done_cyc  <= -1;
            done_cnt  <= 0;
            rd_cnt    <= 0;
            vld_cnt   <= 0;
            sop_cnt   <= 0;
            eop_cnt   <= 0;
            pos       <= 0;
        end else begin
            if (frame_start && start_cyc < 0) start_cyc <= cyc;
            if (bsn_byte_rd && rd_cnt < 64) begin
                rd_ts[rd_cnt] <= int'(bsn_timeslot);
                rd_cnt <= rd_cnt + 1;
            end
            if (blk_vld) begin
                vld_cnt <= vld_cnt + 1;
                if (first_vld < 0) first_vld <= cyc;
                if (blk_sop) begin
                    if (sop_cnt < 64) begin
                        sop_cyc[sop_cnt] <= cyc;
                        sop_idx[sop_cnt] <= int'(blk_ldpc_idx);
                    end
                    if (sop_cnt == 0) bdat[0] <= blk_data;
                    sop_cnt <= sop_cnt + 1;
                    pos <= 1;
                end else begin
                    if (sop_cnt == 1 && pos < 480) bdat[pos] <= blk_data;
                    pos <= pos + 1;
                end
                if (blk_eop && eop_cnt < 64) begin
                    eop_cyc[eop_cnt] <= cyc;
                    eop_pos[eop_cnt] <= blk_sop ? 0 : pos;
                    eop_cnt <= eop_cnt + 1;
                end
            end
            if (frame_done) begin
                if (done_cnt == 0) done_cyc <= cyc;
                done_cnt <= done_cnt + 1;
            end
        end
    end

    task automatic mon_clear();
        gen = gen + 1;
        @(posedge sys_clk); #1;
    endtask

    task automatic fifo_setup(input int n);
        pop_base = pop_total;
        fifo_cnt = n;
    endtask

    task automatic start_frame(input logic [4:0] ts, input logic [5:0] num);
        @(posedge sys_clk); #1;
        frame_start = 1'b1; frame_timeslot = ts; frame_ldpc_num = num;
        @(posedge sys_clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int max, input string name);
        int i;
        for (i = 0; i < max; i++) begin
            @(posedge sys_clk); #2;
            if (done_cnt > 0) break;
        end
        if (i == max) begin
            tests++; fails++;
            $display("FAIL %s: frame_done timeout after %0d cycles", name, max);
        end
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_start = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 rst = 1'b0;
        tests++;
        if ({busy, bsn_byte_rd, bsn_timeslot, fifo_rd_en, blk_vld, blk_data, blk_sop, blk_eop,
             blk_ldpc_idx, frame_done} !== 29'd0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b rd=%b ts=%0d pop=%b vld=%b data=%h sop=%b eop=%b idx=%0d done=%b, required all 0",
                     busy, bsn_byte_rd, bsn_timeslot, fifo_rd_en, blk_vld, blk_data, blk_sop, blk_eop, blk_ldpc_idx, frame_done);
        end
        tests++;
        if (underflow_cnt !== 16'd0) begin
            fails++; $display("FAIL reset_underflow_cnt: got %0d, required 0", underflow_cnt);
        end
        repeat (5) @(posedge sys_clk);
        #1;
        tests++;
        if (busy !== 1'b0 || blk_vld !== 1'b0) begin
            fails++; $display("FAIL reset_idle_hold: busy=%b vld=%b, required 0 0", busy, blk_vld);
        end
    endtask

    task automatic test_nominal();
        int bad = 0, first = -1;
        logic [7:0] exp;
        mon_clear();
        flag_lim = 20; fifo_setup(20);
        start_frame(5'd4, 6'd1);
        wait_done(600, "nominal");
        tests++;
        if (rd_cnt != 1 || rd_ts[0] != 128) begin
            fails++; $display("FAIL nominal_table_index: reads=%0d idx=%0d, required 1 128", rd_cnt, rd_ts[0]);
        end
        for (int i = 0; i < 480; i++) begin
            exp = (i < 20) ? 8'(i + 1) : 8'h00;
            if (bdat[i] !== exp) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL nominal_data: %0d bad bytes, first at %0d got %h", bad, first, bdat[first]);
        end
        tests++;
        if (pop_total - pop_base != 20) begin
            fails++; $display("FAIL nominal_pops: got %0d, required 20", pop_total - pop_base);
        end
        tests++;
        if (sop_cnt != 1 || eop_cnt != 1 || eop_pos[0] != 479 || vld_cnt != 480) begin
            fails++; $display("FAIL nominal_framing: sop=%0d eop=%0d eop_pos=%0d vld=%0d, required 1 1 479 480",
                              sop_cnt, eop_cnt, eop_pos[0], vld_cnt);
        end
        tests++;
        if (done_cyc - eop_cyc[0] != 1 || done_cnt != 1) begin
            fails++; $display("FAIL nominal_done_timing: eop->done=%0d count=%0d, required 1 1",
                              done_cyc - eop_cyc[0], done_cnt);
        end
        tests++;
        if (first_vld - start_cyc != 3) begin
            fails++; $display("FAIL nominal_latency: got %0d, required 3", first_vld - start_cyc);
        end
        tests++;
        if (busy !== 1'b0 || underflow_cnt !== 16'd0) begin
            fails++; $display("FAIL nominal_end_state: busy=%b unf=%0d, required 0 0", busy, underflow_cnt);
        end
    endtask

    task automatic test_multi_block();
        mon_clear();
        flag_lim = 1000; fifo_setup(100000);
        start_frame(5'd20, 6'd3);
        wait_done(1600, "multi");
        tests++;
        if (rd_cnt != 3 || rd_ts[0] != 640 || rd_ts[1] != 641 || rd_ts[2] != 642) begin
            fails++; $display("FAIL multi_table_index: n=%0d %0d %0d %0d, required 3 640 641 642",
                              rd_cnt, rd_ts[0], rd_ts[1], rd_ts[2]);
        end
        tests++;
        if (sop_cnt != 3 || sop_idx[0] != 0 || sop_idx[1] != 1 || sop_idx[2] != 2) begin
            fails++; $display("FAIL multi_ldpc_idx: n=%0d %0d %0d %0d, required 3 0 1 2",
                              sop_cnt, sop_idx[0], sop_idx[1], sop_idx[2]);
        end
        tests++;
        if (sop_cyc[1] - eop_cyc[0] != 2 || sop_cyc[2] - eop_cyc[1] != 2 || eop_cyc[0] - sop_cyc[0] != 479) begin
            fails++; $display("FAIL multi_gap: eop0->sop1=%0d eop1->sop2=%0d len0=%0d, required 2 2 479",
                              sop_cyc[1] - eop_cyc[0], sop_cyc[2] - eop_cyc[1], eop_cyc[0] - sop_cyc[0]);
        end
        tests++;
        if (pop_total - pop_base != 1440 || vld_cnt != 1440) begin
            fails++; $display("FAIL multi_pops: pops=%0d vld=%0d, required 1440 1440", pop_total - pop_base, vld_cnt);
        end
    endtask

    task automatic test_underflow();
        int bad = 0, first = -1;
        logic [7:0] exp;
        mon_clear();
        flag_lim = 1000; fifo_setup(100);
        start_frame(5'd2, 6'd1);
        wait_done(600, "underflow");
        for (int i = 0; i < 480; i++) begin
            exp = (i < 100) ? 8'(i + 1) : 8'h00;
            if (bdat[i] !== exp) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL underflow_data: %0d bad bytes, first at %0d got %h", bad, first, bdat[first]);
        end
        tests++;
        if (underflow_cnt !== 16'd380) begin
            fails++; $display("FAIL underflow_cnt: got %0d, required 380", underflow_cnt);
        end
        tests++;
        if (pop_total - pop_base != 100) begin
            fails++; $display("FAIL underflow_pops: got %0d, required 100", pop_total - pop_base);
        end
    endtask

    task automatic test_zero_blocks();
        mon_clear();
        flag_lim = 0; fifo_setup(0);
        start_frame(5'd5, 6'd0);
        wait_done(20, "zero_blocks");
        tests++;
        if (rd_cnt != 0 || vld_cnt != 0) begin
            fails++; $display("FAIL zero_no_read: reads=%0d vld=%0d, required 0 0", rd_cnt, vld_cnt);
        end
        tests++;
        if (done_cyc - start_cyc != 2 || done_cnt != 1) begin
            fails++; $display("FAIL zero_done_timing: start->done=%0d count=%0d, required 2 1",
                              done_cyc - start_cyc, done_cnt);
        end
    endtask

    task automatic test_clamp();
        mon_clear();
        flag_lim = 0;
        start_frame(5'd1, 6'd40);
        wait_done(32 * 481 + 100, "clamp");
        tests++;
        if (sop_cnt != 32 || eop_cnt != 32 || rd_cnt != 32) begin
            fails++; $display("FAIL clamp_blocks: sop=%0d eop=%0d reads=%0d, required 32 32 32", sop_cnt, eop_cnt, rd_cnt);
        end
        tests++;
        if (rd_ts[31] != 63 || sop_idx[31] != 31) begin
            fails++; $display("FAIL clamp_last_idx: table=%0d idx=%0d, required 63 31", rd_ts[31], sop_idx[31]);
        end
    endtask

    task automatic test_start_while_busy();
        mon_clear();
        flag_lim = 0;
        start_frame(5'd7, 6'd1);
        repeat (10) @(posedge sys_clk);
        #1;
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL busy_during_frame: got %b, required 1", busy);
        end
        frame_start = 1'b1; frame_timeslot = 5'd9; frame_ldpc_num = 6'd2;
        @(posedge sys_clk); #1;
        frame_start = 1'b0;
        wait_done(600, "start_while_busy");
        repeat (10) @(posedge sys_clk);
        #2;
        tests++;
        if (rd_cnt != 1 || sop_cnt != 1 || done_cnt != 1 || rd_ts[0] != 224) begin
            fails++; $display("FAIL busy_start_ignored: reads=%0d sop=%0d done=%0d idx=%0d, required 1 1 1 224",
                              rd_cnt, sop_cnt, done_cnt, rd_ts[0]);
        end
    endtask

    task automatic test_mid_reset();
        int i;
        mon_clear();
        flag_lim = 1000; fifo_setup(100000);
        start_frame(5'd3, 6'd3);
        for (i = 0; i < 2000; i++) begin
            @(posedge sys_clk); #2;
            if (sop_cnt == 2 && pos >= 200) break;
        end
        tests++;
        if (i == 2000) begin
            fails++; $display("FAIL midreset_reach: block 1 byte 200 not reached, sop=%0d pos=%0d", sop_cnt, pos);
        end
        rst = 1'b1;
        @(posedge sys_clk); #1;
        tests++;
        if (blk_vld !== 1'b0 || busy !== 1'b0 || blk_eop !== 1'b0 || fifo_rd_en !== 1'b0 || bsn_byte_rd !== 1'b0) begin
            fails++; $display("FAIL midreset_outputs: vld=%b busy=%b eop=%b pop=%b rd=%b, required all 0",
                              blk_vld, busy, blk_eop, fifo_rd_en, bsn_byte_rd);
        end
        tests++;
        if (underflow_cnt !== 16'd0) begin
            fails++; $display("FAIL midreset_underflow_clr: got %0d, required 0", underflow_cnt);
        end
        rst = 1'b0;
        repeat (3) @(posedge sys_clk);
        #2;
        tests++;
        if (eop_cnt != 1) begin
            fails++; $display("FAIL midreset_no_eop: eops=%0d, required 1", eop_cnt);
        end
        mon_clear();
        start_frame(5'd3, 6'd1);
        wait_done(600, "midreset_restart");
        tests++;
        if (rd_ts[0] != 96 || sop_idx[0] != 0 || sop_cnt != 1) begin
            fails++; $display("FAIL midreset_restart: idx=%0d ldpc=%0d blocks=%0d, required 96 0 1",
                              rd_ts[0], sop_idx[0], sop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_multi_block();
        test_underflow();
        test_zero_blocks();
        test_clamp();
        test_start_while_busy();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
